// File: rtl/vend_dispense_sequencer_pkg.sv
// Shared encodings for the dispense sequencer: FSM states, order status codes,
// coin hopper drives and their dollar values.
package vend_defs;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_CHECK    = 3'd1,
      S_VEND_ON  = 3'd2,
      S_VEND_GAP = 3'd3,
      S_CHG_ON   = 3'd4,
      S_CHG_GAP  = 3'd5,
      S_DONE     = 3'd6
   } state_t;

   typedef enum logic [1:0] {
      ST_OK        = 2'd0,
      ST_BAD_REQ   = 2'd1,
      ST_SOLD_OUT  = 2'd2,
      ST_UNDERPAID = 2'd3
   } status_t;

   localparam logic [2:0] COIN_TEN  = 3'b100;
   localparam logic [2:0] COIN_FIVE = 3'b010;
   localparam logic [2:0] COIN_ONE  = 3'b001;

   localparam logic [7:0] VAL_TEN  = 8'd10;
   localparam logic [7:0] VAL_FIVE = 8'd5;
   localparam logic [7:0] VAL_ONE  = 8'd1;

   localparam int TMR_W = 8;

   // Greedy change: largest coin not exceeding what is still owed.
   function automatic logic [2:0] pick_coin(input logic [7:0] owed);
      if (owed >= VAL_TEN)       return COIN_TEN;
      else if (owed >= VAL_FIVE) return COIN_FIVE;
      else                       return COIN_ONE;
   endfunction

   function automatic logic [7:0] coin_value(input logic [2:0] coin);
      case (coin)
         COIN_TEN:  return VAL_TEN;
         COIN_FIVE: return VAL_FIVE;
         default:   return VAL_ONE;
      endcase
   endfunction

endpackage

// File: rtl/vend_dispense_sequencer_pulse_timer.sv
// Down-counter timing every ON/GAP phase; loaded with (length-1) on phase entry,
// 'expired' marks the last cycle of the phase.
module pulse_timer
   import vend_defs::*;
#(
   parameter int W = TMR_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         expired
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)               cnt_d = load_val;
      else if (cnt_q != '0)   cnt_d = cnt_q - W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/vend_dispense_sequencer.sv
// Vend sequencer: validates an accepted order against stock, pulses the product
// motor once per unit, then pays change greedily through the coin hopper.
module vend_dispense_sequencer
   import vend_defs::*;
#(
   parameter int         NUM_PRODUCTS = 5,
   parameter logic [3:0] STOCK_INIT   = 4'd9,
   parameter int         MOTOR_CYCLES = 4,
   parameter int         COIN_CYCLES  = 2,
   parameter int         GAP_CYCLES   = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [2:0]              req_product,
   input  logic [1:0]              req_qty,
   input  logic [7:0]              req_price,
   input  logic [7:0]              req_paid,
   input  logic                    restock,
   output logic [NUM_PRODUCTS-1:0] motor_en,
   output logic [2:0]              coin_out,
   output logic [7:0]              change_owed,
   output logic                    busy,
   output logic                    done,
   output logic [1:0]              status,
   input  logic [2:0]              stock_sel,
   output logic [3:0]              stock_level,
   output logic [2:0]              state_dbg
);

   localparam logic [TMR_W-1:0] MOTOR_LD = TMR_W'(MOTOR_CYCLES - 1);
   localparam logic [TMR_W-1:0] COIN_LD  = TMR_W'(COIN_CYCLES - 1);
   localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(GAP_CYCLES - 1);

   // Handshake: an order transfers on a clk edge where req_valid && req_ready;
   // req_ready is high only in IDLE with no restock, and order fields are
   // captured on that edge and ignored for the rest of the order.
   state_t      state_q, state_d;
   status_t     status_q, status_d;
   logic [2:0]  prod_q, prod_d;
   logic [1:0]  qty_q, qty_d;
   logic [7:0]  price_q, price_d;
   logic [7:0]  paid_q, paid_d;
   logic [7:0]  change_q, change_d;
   logic [1:0]  units_q, units_d;
   logic [3:0]  stock_q [NUM_PRODUCTS];
   logic [3:0]  stock_d [NUM_PRODUCTS];

   logic              tmr_load, tmr_expired;
   logic [TMR_W-1:0]  tmr_val;
   logic              id_valid;
   logic [3:0]        cur_stock;
   logic [9:0]        total;
   logic [9:0]        paid_ext;
   logic [2:0]        coin_sel;

   pulse_timer #(.W(TMR_W)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .expired  (tmr_expired)
   );

   always_comb begin
      id_valid  = 1'b0;
      cur_stock = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (prod_q == 3'(i + 1)) begin
            id_valid  = 1'b1;
            cur_stock = stock_q[i];
         end
      end
   end

   always_comb begin
      stock_level = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (stock_sel == 3'(i + 1)) stock_level = stock_q[i];
      end
   end

   assign total    = {2'b00, price_q} * {8'b0, qty_q};
   assign paid_ext = {2'b00, paid_q};
   assign coin_sel = pick_coin(change_q);

   always_comb begin
      state_d   = state_q;
      status_d  = status_q;
      prod_d    = prod_q;
      qty_d     = qty_q;
      price_d   = price_q;
      paid_d    = paid_q;
      change_d  = change_q;
      units_d   = units_q;
      stock_d   = stock_q;
      tmr_load  = 1'b0;
      tmr_val   = '0;
      motor_en  = '0;
      coin_out  = '0;
      done      = 1'b0;
      req_ready = (state_q == S_IDLE) && !restock;
      busy      = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (restock) begin
               for (int i = 0; i < NUM_PRODUCTS; i++) stock_d[i] = STOCK_INIT;
            end else if (req_valid) begin
               prod_d  = req_product;
               qty_d   = req_qty;
               price_d = req_price;
               paid_d  = req_paid;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (!id_valid || qty_q == 2'd0)     status_d = ST_BAD_REQ;
            else if (cur_stock < {2'b00, qty_q}) status_d = ST_SOLD_OUT;
            else if (paid_ext < total)           status_d = ST_UNDERPAID;
            else                                 status_d = ST_OK;

            if (status_d == ST_OK) begin
               for (int i = 0; i < NUM_PRODUCTS; i++) begin
                  if (prod_q == 3'(i + 1)) stock_d[i] = stock_q[i] - {2'b00, qty_q};
               end
               change_d = 8'(paid_ext - total);
               units_d  = qty_q;
               state_d  = S_VEND_ON;
               tmr_load = 1'b1;
               tmr_val  = MOTOR_LD;
            end else begin
               // Rejected order: everything paid goes back as change.
               change_d = paid_q;
               if (paid_q != 8'd0) begin
                  state_d  = S_CHG_ON;
                  tmr_load = 1'b1;
                  tmr_val  = COIN_LD;
               end else begin
                  state_d = S_DONE;
               end
            end
         end
         S_VEND_ON: begin
            for (int i = 0; i < NUM_PRODUCTS; i++) motor_en[i] = (prod_q == 3'(i + 1));
            if (tmr_expired) begin
               state_d  = S_VEND_GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         S_VEND_GAP: begin
            if (tmr_expired) begin
               units_d  = units_q - 2'd1;
               tmr_load = 1'b1;
               if (units_q != 2'd1) begin
                  state_d = S_VEND_ON;
                  tmr_val = MOTOR_LD;
               end else if (change_q != 8'd0) begin
                  state_d = S_CHG_ON;
                  tmr_val = COIN_LD;
               end else begin
                  state_d  = S_DONE;
                  tmr_load = 1'b0;
               end
            end
         end
         S_CHG_ON: begin
            coin_out = coin_sel;
            if (tmr_expired) begin
               change_d = change_q - coin_value(coin_sel);
               state_d  = S_CHG_GAP;
               tmr_load = 1'b1;
               tmr_val  = GAP_LD;
            end
         end
         S_CHG_GAP: begin
            if (tmr_expired) begin
               if (change_q == 8'd0) begin
                  state_d = S_DONE;
               end else begin
                  state_d  = S_CHG_ON;
                  tmr_load = 1'b1;
                  tmr_val  = COIN_LD;
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         status_q <= ST_OK;
         prod_q   <= '0;
         qty_q    <= '0;
         price_q  <= '0;
         paid_q   <= '0;
         change_q <= '0;
         units_q  <= '0;
         for (int i = 0; i < NUM_PRODUCTS; i++) stock_q[i] <= STOCK_INIT;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         prod_q   <= prod_d;
         qty_q    <= qty_d;
         price_q  <= price_d;
         paid_q   <= paid_d;
         change_q <= change_d;
         units_q  <= units_d;
         stock_q  <= stock_d;
      end
   end

   assign change_owed = change_q;
   assign status      = status_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_vend_dispense_sequencer.sv
// Directed bench for vend_dispense_sequencer: orders drive a reference stock
// model, expected motor/coin pulses are queued and matched as the DUT emits them.
module tb_vend_dispense_sequencer;

   localparam int MOTOR = 4;
   localparam int COIN  = 2;
   localparam int GAP   = 2;
   localparam logic [2:0] C_TEN  = 3'b100;
   localparam logic [2:0] C_FIVE = 3'b010;
   localparam logic [2:0] C_ONE  = 3'b001;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic [2:0] req_product = '0;
   logic [1:0] req_qty = '0;
   logic [7:0] req_price = '0;
   logic [7:0] req_paid = '0;
   logic       restock = 1'b0;
   logic [4:0] motor_en;
   logic [2:0] coin_out;
   logic [7:0] change_owed;
   logic       busy;
   logic       done;
   logic [1:0] status;
   logic [2:0] stock_sel = '0;
   logic [3:0] stock_level;
   logic [2:0] state_dbg;

   int checks = 0;
   int errors = 0;
   int mstock [8];
   logic [15:0] exp_q[$];
   bit mon_en = 1'b0;

   vend_dispense_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_product (req_product),
      .req_qty     (req_qty),
      .req_price   (req_price),
      .req_paid    (req_paid),
      .restock     (restock),
      .motor_en    (motor_en),
      .coin_out    (coin_out),
      .change_owed (change_owed),
      .busy        (busy),
      .done        (done),
      .status      (status),
      .stock_sel   (stock_sel),
      .stock_level (stock_level),
      .state_dbg   (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) mstock[i] = (i >= 1 && i <= 5) ? 9 : 0;
   endtask

   task automatic check_all_stock(input string tag);
      for (int i = 0; i < 8; i++) begin
         stock_sel = 3'(i);
         #1;
         check($sformatf("%s_stock[%0d]", tag, i), {28'b0, stock_level}, mstock[i]);
      end
   endtask

   // Pulse monitor: each rising pulse pops one expected {kind, drive, owed} entry.
   logic [4:0] prev_motor = '0;
   logic [2:0] prev_coin = '0;
   int width = 0;
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_motor = '0;
         prev_coin  = '0;
         width      = 0;
      end else begin
         if (motor_en != prev_motor || coin_out != prev_coin) begin
            if (prev_motor == '0 && prev_coin == '0) begin
               check("motor_coin_exclusive", {31'b0, (motor_en != '0 && coin_out != '0)}, 0);
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", {11'b0, motor_en, 8'b0, coin_out, 5'b0}, 0);
               end else if (motor_en != '0) begin
                  check("motor_pulse", {16'b0, 2'b01, 1'b0, motor_en, change_owed}, {16'b0, exp_q.pop_front()});
               end else begin
                  check("coin_pulse", {16'b0, 2'b10, 3'b0, coin_out, change_owed}, {16'b0, exp_q.pop_front()});
               end
               width = 1;
            end else if (motor_en == '0 && coin_out == '0) begin
               check(prev_motor != '0 ? "motor_width" : "coin_width", width,
                     prev_motor != '0 ? MOTOR : COIN);
            end else begin
               check("pulse_changed_midway", {24'b0, motor_en, coin_out}, {24'b0, prev_motor, prev_coin});
            end
         end else if (motor_en != '0 || coin_out != '0) begin
            width++;
         end
         prev_motor = motor_en;
         prev_coin  = coin_out;
      end
   end

   task automatic send_order(input logic [2:0] prod, input logic [1:0] qty,
                             input logic [7:0] price, input logic [7:0] paid, input bit poke);
      int total, chg, st, exp_lat, cyc;
      bit seen, rdy;
      logic [4:0] mcode;
      total = int'(price) * int'(qty);
      if (prod == 0 || prod > 5 || qty == 0) st = 1;
      else if (mstock[prod] < int'(qty))     st = 2;
      else if (int'(paid) < total)          st = 3;
      else                                  st = 0;
      exp_lat = 2;
      if (st == 0) begin
         mstock[prod] -= int'(qty);
         chg = int'(paid) - total;
         mcode = 5'b00001 << (prod - 3'd1);
         for (int k = 0; k < int'(qty); k++) exp_q.push_back({2'b01, 1'b0, mcode, 8'(chg)});
         exp_lat += int'(qty) * (MOTOR + GAP);
      end else begin
         chg = int'(paid);
      end
      while (chg > 0) begin
         if (chg >= 10)     begin exp_q.push_back({2'b10, 3'b0, C_TEN,  8'(chg)}); chg -= 10; end
         else if (chg >= 5) begin exp_q.push_back({2'b10, 3'b0, C_FIVE, 8'(chg)}); chg -= 5;  end
         else               begin exp_q.push_back({2'b10, 3'b0, C_ONE,  8'(chg)}); chg -= 1;  end
         exp_lat += COIN + GAP;
      end

      @(negedge clk);
      rdy = 1'b0;
      for (int c = 0; c < 50 && !rdy; c++) begin
         if (req_ready) rdy = 1'b1; else @(negedge clk);
      end
      check("ready_before_accept", {31'b0, rdy}, 1);
      req_valid = 1'b1; req_product = prod; req_qty = qty; req_price = price; req_paid = paid;
      @(posedge clk);
      #1;
      req_valid   = 1'b0;
      req_product = 3'($urandom_range(0, 7));
      req_qty     = 2'($urandom_range(0, 3));
      req_price   = 8'($urandom_range(0, 255));
      req_paid    = 8'($urandom_range(0, 255));
      check("busy_after_accept", {31'b0, busy}, 1);

      cyc = 0;
      seen = 1'b0;
      for (int c = 0; c < 400 && !seen; c++) begin
         @(negedge clk);
         cyc++;
         if (done) seen = 1'b1;
         if (poke && cyc == 3) begin
            req_valid = 1'b1; req_product = 3'd1; req_qty = 2'd1; req_price = 8'd1; req_paid = 8'd1;
            #1;
            check("ready_low_while_busy", {31'b0, req_ready}, 0);
         end
         if (poke && cyc == 5) req_valid = 1'b0;
      end
      check("done_seen", {31'b0, seen}, 1);
      check("latency", cyc, exp_lat);
      check("status", {30'b0, status}, st);
      check("change_at_done", {24'b0, change_owed}, 0);
      @(negedge clk);
      check("idle_after_done", {31'b0, busy}, 0);
      check("done_one_cycle", {31'b0, done}, 0);
      check("status_held", {30'b0, status}, st);
      check("queue_drained", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check("rst_req_ready", {31'b0, req_ready}, 1);
      check("rst_busy", {31'b0, busy}, 0);
      check("rst_done", {31'b0, done}, 0);
      check("rst_motor", {27'b0, motor_en}, 0);
      check("rst_coin", {29'b0, coin_out}, 0);
      check("rst_change", {24'b0, change_owed}, 0);
      check("rst_status", {30'b0, status}, 0);
      check_all_stock("rst");
      @(negedge clk);
      reset = 1'b1;
      mon_en = 1'b1;

      // OK with change, plus an order offered while busy that must be ignored
      send_order(3'd2, 2'd2, 8'd6, 8'd20, 1'b1);
      // exact payment, no coins
      send_order(3'd5, 2'd3, 8'd1, 8'd3, 1'b0);
      check_all_stock("after_ok");

      // drain slot 1 to one unit, then sold out
      send_order(3'd1, 2'd3, 8'd1, 8'd3, 1'b0);
      send_order(3'd1, 2'd3, 8'd1, 8'd3, 1'b0);
      send_order(3'd1, 2'd2, 8'd1, 8'd2, 1'b0);
      send_order(3'd1, 2'd2, 8'd5, 8'd50, 1'b0);
      check_all_stock("sold_out");

      // underpaid, bad id, zero quantity with nothing paid
      send_order(3'd3, 2'd1, 8'd10, 8'd7, 1'b0);
      send_order(3'd6, 2'd1, 8'd3, 8'd4, 1'b0);
      send_order(3'd0, 2'd1, 8'd3, 8'd0, 1'b0);
      send_order(3'd2, 2'd0, 8'd3, 8'd0, 1'b0);

      for (int n = 0; n < 6; n++) begin
         send_order(3'($urandom_range(0, 6)), 2'($urandom_range(0, 3)),
                    8'($urandom_range(1, 12)), 8'($urandom_range(0, 40)), 1'b0);
      end
      check_all_stock("random");

      // restock and order offered together: restock wins
      @(negedge clk);
      restock = 1'b1;
      req_valid = 1'b1; req_product = 3'd2; req_qty = 2'd1; req_price = 8'd1; req_paid = 8'd1;
      #1;
      check("ready_low_on_restock", {31'b0, req_ready}, 0);
      @(posedge clk);
      #1;
      check("restock_not_accepted", {29'b0, state_dbg}, {29'b0, vend_defs::S_IDLE});
      restock = 1'b0;
      req_valid = 1'b0;
      model_reset();
      check_all_stock("restock");

      // asynchronous reset during the second motor pulse
      send_order(3'd4, 2'd1, 8'd2, 8'd2, 1'b0);
      mon_en = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_product = 3'd4; req_qty = 2'd2; req_price = 8'd1; req_paid = 8'd5;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (9) @(negedge clk);
      check("second_motor_pulse", {27'b0, motor_en}, 5'b01000);
      #1;
      reset = 1'b0;
      #1;
      check("midrst_motor", {27'b0, motor_en}, 0);
      check("midrst_coin", {29'b0, coin_out}, 0);
      check("midrst_ready", {31'b0, req_ready}, 1);
      check("midrst_busy", {31'b0, busy}, 0);
      check("midrst_status", {30'b0, status}, 0);
      model_reset();
      check_all_stock("midrst");
      @(negedge clk);
      reset = 1'b1;
      exp_q.delete();
      @(negedge clk);
      mon_en = 1'b1;
      send_order(3'd4, 2'd1, 8'd2, 8'd13, 1'b0);
      check_all_stock("recovery");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
